// File: rtl/dbg_uart_pkg.sv
// Shared types and helpers for the debug UART: byte type, FSM state enum, bit-period math.
package dbg_uart_pkg;

    typedef logic [7:0] u8_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_st_t;

    // Clocks per bit, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/dbg_uart_tx.sv
// 8N1 transmitter: latches a byte on tx_start and serialises it LSB first on rxd.
module dbg_uart_tx
    import dbg_uart_pkg::*;
#(
    parameter int DIV = 868
) (
    input  logic clk,
    input  logic xreset,
    input  u8_t  tx_data,
    input  logic tx_start,
    output logic tx_busy,
    output logic rxd
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    uart_st_t        st;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    u8_t             shreg;
    logic            bit_end;

    assign bit_end = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            st      <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_busy <= 1'b0;
            rxd     <= 1'b1;
        end else begin
            case (st)
                IDLE: begin
                    cnt <= '0;
                    if (tx_start) begin
                        shreg   <= tx_data;
                        st      <= START;
                        tx_busy <= 1'b1;
                        rxd     <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        rxd     <= shreg[0];
                        shreg   <= shreg >> 1;
                        st      <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            rxd <= 1'b1;
                            st  <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            rxd     <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    // busy drops on the same edge the stop bit ends, so a start in
                    // this cycle is still seen in STOP and ignored
                    if (bit_end) begin
                        cnt     <= '0;
                        tx_busy <= 1'b0;
                        st      <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dbg_uart.sv
// Debug UART top: inline 8N1 receiver on txd plus dbg_uart_tx driving rxd.
// Optional console echo of received bytes when DBGUART_PRINT_EN is defined.
module dbg_uart
    import dbg_uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200
) (
    input  logic clk,
    input  logic xreset,
    input  logic txd,
    output logic rxd,
    output u8_t  rx_data,
    output logic rx_valid,
    output logic rx_ferr,
    input  u8_t  tx_data,
    input  logic tx_start,
    output logic tx_busy
);

    localparam int DIV  = calc_div(CLK_HZ, BAUD);
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

    // sync[1:0] is the synchronizer, sync[2] the previous synchronized value.
    // Resetting to 0 means a fresh high->low transition is needed after reset.
    logic [2:0]      sync;
    uart_st_t        st;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    u8_t             shreg;

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            sync     <= '0;
            st       <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            sync     <= {sync[1:0], txd};
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (st)
                IDLE: begin
                    cnt <= '0;
                    if (sync[2] && !sync[1])
                        st <= START;
                end
                START: begin
                    if (cnt == CW'(HALF - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        st      <= sync[1] ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CW'(DIV - 1)) begin
                        cnt   <= '0;
                        shreg <= {sync[1], shreg[7:1]};
                        if (bit_idx == 3'd7)
                            st <= STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    // after a low stop bit, IDLE only re-arms once the line has been high
                    if (cnt == CW'(DIV - 1)) begin
                        cnt <= '0;
                        st  <= IDLE;
                        if (sync[1]) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    dbg_uart_tx #(.DIV(DIV)) u_tx (
        .clk      (clk),
        .xreset   (xreset),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .rxd      (rxd)
    );

`ifdef DBGUART_PRINT_EN
    always @(posedge clk) begin
        if (xreset && rx_valid)
            $write("%c", rx_data);
        if (xreset && rx_ferr)
            $display("dbg_uart: framing error");
    end
`else
    // silent build: no console side effects
`endif

endmodule

// File: tb/tb_dbg_uart.sv
// Randomized self-checking bench for dbg_uart: byte-level scoreboard for rx, bit-level tx checks.
module tb_dbg_uart;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 60_000;
    localparam int DIV    = 17;   // 16.67 rounds up to 17
    localparam int HALF   = 8;

    logic       clk = 1'b0;
    logic       xreset = 1'b0;
    logic       txd = 1'b1;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy;

    int         errors = 0;
    int         checks = 0;
    longint     cyc = 0;
    longint     frame_t0 = 0;
    longint     last_valid_cyc = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    dbg_uart #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk      (clk),
        .xreset   (xreset),
        .txd      (txd),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rx_valid) begin
            got_q.push_back(rx_data);
            n_valid++;
            last_valid_cyc = cyc;
        end
        if (rx_ferr) n_ferr++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One 8N1 frame on txd; stop bit value selectable. Good frames go to the scoreboard.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) frame_t0 = cyc;
            txd = f[k];
            repeat (DIV - 1) @(negedge clk);
        end
        if (stop) exp_q.push_back(b);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        txd = 1'b1;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic check_rx(input string tag);
        logic [7:0] e;
        logic [7:0] g;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            chk({tag, "_byte"}, {24'h0, g}, {24'h0, e});
        end
        got_q.delete();
    endtask

    // Sends one byte and checks the rxd waveform mid-bit, busy length, and that a
    // start during busy is dropped. With poke_fall, also asserts start in the
    // cycle busy falls and checks it is only taken one cycle later.
    task automatic tx_check(input logic [7:0] b, input bit poke_fall);
        logic [9:0] f;
        int busy_n;
        f = {1'b1, b, 1'b0};
        busy_n = 0;
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = ~b;
        chk("tx_start_low", {31'h0, rxd}, 32'h0);
        for (int i = 0; i < 10 * DIV; i++) begin
            if (tx_busy) busy_n++;
            if (i % DIV == HALF)
                chk($sformatf("tx_bit%0d", i / DIV), {31'h0, rxd}, {31'h0, f[i / DIV]});
            if (i == 5) tx_start = 1'b1;
            if (i == 6) tx_start = 1'b0;
            if (poke_fall && i == 10 * DIV - 1) tx_start = 1'b1;
            @(negedge clk);
        end
        chk("tx_busy_len", busy_n, 10 * DIV);
        chk("tx_busy_fall", {31'h0, tx_busy}, 32'h0);
        chk("tx_idle_high", {31'h0, rxd}, 32'h1);
        if (poke_fall) begin
            @(negedge clk);
            tx_start = 1'b0;
            chk("tx_accept_after_fall", {31'h0, tx_busy}, 32'h1);
            chk("tx_accept_rxd", {31'h0, rxd}, 32'h0);
            repeat (10 * DIV) @(negedge clk);
            chk("tx_second_done", {31'h0, tx_busy}, 32'h0);
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] last_good;
        logic [9:0] f;
        int nv0;
        int nf0;
        longint lat;

        xreset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rxd", {31'h0, rxd}, 32'h1);
        chk("rst_rx_data", {24'h0, rx_data}, 32'h0);
        chk("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        chk("rst_rx_ferr", {31'h0, rx_ferr}, 32'h0);
        chk("rst_tx_busy", {31'h0, tx_busy}, 32'h0);
        @(negedge clk);
        xreset = 1'b1;
        idle(3 * DIV);

        // single 'A' with latency inside the stop bit
        send_frame(8'h41, 1'b1);
        idle(2 * DIV);
        lat = last_valid_cyc - frame_t0;
        chk("rx_latency", {31'h0, (lat >= 9 * DIV) && (lat < 10 * DIV)}, 32'h1);
        chk("rx_no_ferr", n_ferr, 0);
        check_rx("a41");

        send_frame(8'h48, 1'b1);
        send_frame(8'h69, 1'b1);
        send_frame(8'h0A, 1'b1);
        idle(2 * DIV);
        check_rx("hi");

        for (int n = 0; n < 8; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap > 0) idle(gap * 5);
            send_frame(8'($urandom), 1'b1);
        end
        idle(2 * DIV);
        last_good = exp_q[exp_q.size() - 1];
        check_rx("rand");

        // framing error leaves rx_data alone, then recovery
        nv0 = n_valid;
        nf0 = n_ferr;
        send_frame(8'h55, 1'b0);
        idle(2 * DIV);
        chk("ferr_count", n_ferr - nf0, 1);
        chk("ferr_no_valid", n_valid - nv0, 0);
        chk("ferr_data_kept", {24'h0, rx_data}, {24'h0, last_good});
        send_frame(8'h33, 1'b1);
        idle(2 * DIV);
        check_rx("after_ferr");

        // short low glitch shorter than half a bit
        nv0 = n_valid;
        nf0 = n_ferr;
        @(negedge clk);
        txd = 1'b0;
        repeat (HALF - 3) @(negedge clk);
        txd = 1'b1;
        idle(2 * DIV);
        chk("glitch_no_valid", n_valid - nv0, 0);
        chk("glitch_no_ferr", n_ferr - nf0, 0);
        send_frame(8'($urandom), 1'b1);
        idle(2 * DIV);
        check_rx("after_glitch");

        tx_check(8'hA5, 1'b0);
        tx_check(8'($urandom), 1'b1);

        // full duplex
        b = 8'($urandom);
        fork
            begin
                send_frame(8'($urandom), 1'b1);
                send_frame(8'($urandom), 1'b1);
            end
            tx_check(b, 1'b0);
        join
        idle(2 * DIV);
        check_rx("duplex");

        // reset mid-frame on both directions
        nv0 = n_valid;
        nf0 = n_ferr;
        f = {1'b1, 8'hF0, 1'b0};
        @(negedge clk);
        tx_data  = 8'($urandom);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        for (int c = 0; c < 10 * DIV; c++) begin
            txd = f[c / DIV];
            if (c == 5 * DIV + 3) begin
                xreset = 1'b0;
                #1;
                chk("mid_rst_rxd", {31'h0, rxd}, 32'h1);
                chk("mid_rst_busy", {31'h0, tx_busy}, 32'h0);
                chk("mid_rst_valid", {31'h0, rx_valid}, 32'h0);
            end
            if (c == 5 * DIV + 8) xreset = 1'b1;
            @(negedge clk);
        end
        idle(3 * DIV);
        chk("post_rst_no_valid", n_valid - nv0, 0);
        chk("post_rst_no_ferr", n_ferr - nf0, 0);
        chk("post_rst_rx_data", {24'h0, rx_data}, 32'h0);
        chk("post_rst_busy", {31'h0, tx_busy}, 32'h0);
        chk("post_rst_rxd", {31'h0, rxd}, 32'h1);
        got_q.delete();
        send_frame(8'h5A, 1'b1);
        idle(2 * DIV);
        check_rx("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
